// File: rtl/mnist_batch_sched.sv
// Batch scheduler for the MNIST accelerator: launches each stored image, waits for done, scores the result.
// Define SCHED_PERF_EN to build worst-case per-image latency tracking on max_lat.
module mnist_batch_sched #(
  parameter int NUM_IMG = 10,
  parameter int IDX_W   = 4,
  parameter int TIMEOUT = 5000,
  parameter int CYC_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             abort,
  output logic [IDX_W-1:0] img_sel,
  input  logic [3:0]       exp_digit,
  output logic             acc_start,
  input  logic             acc_done,
  input  logic [3:0]       acc_digit,
  output logic             busy,
  output logic             batch_done,
  output logic [IDX_W:0]   correct_cnt,
  output logic [3:0]       last_digit,
  output logic             err_timeout,
  output logic [CYC_W-1:0] total_cycles,
  output logic [15:0]      max_lat
);

  localparam int CNT_BITS = $clog2(TIMEOUT + 1);
  localparam int WAIT_W   = (CNT_BITS > 16) ? CNT_BITS : 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    DRAIN  = 3'd3,
    NEXT   = 3'd4,
    REPORT = 3'd5
  } state_t;

  state_t            state_r;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [WAIT_W-1:0] wait_nx_s;
  logic              counting_s;
  logic              hit_s;

  // Derived per-cycle terms: next wait count, batch-time accounting window, label match
  always_comb begin
    wait_nx_s  = wait_cnt_r + WAIT_W'(1);
    hit_s      = (acc_digit == exp_digit);
    counting_s = 1'b0;
    case (state_r)
      LAUNCH, WAIT, DRAIN, NEXT: counting_s = 1'b1;
      default:                   counting_s = 1'b0;
    endcase
  end

  // Scheduler FSM with registered outputs; abort overrides every transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      wait_cnt_r   <= '0;
      img_sel      <= '0;
      acc_start    <= 1'b0;
      busy         <= 1'b0;
      batch_done   <= 1'b0;
      correct_cnt  <= '0;
      last_digit   <= 4'd0;
      err_timeout  <= 1'b0;
      total_cycles <= '0;
    end else begin
      acc_start  <= 1'b0;
      batch_done <= 1'b0;
      if (counting_s && (total_cycles != {CYC_W{1'b1}})) begin
        total_cycles <= total_cycles + CYC_W'(1);
      end
      if (abort && (state_r != IDLE)) begin
        state_r <= IDLE;
        busy    <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (run) begin
              correct_cnt  <= '0;
              err_timeout  <= 1'b0;
              total_cycles <= '0;
              img_sel      <= '0;
              acc_start    <= 1'b1;
              busy         <= 1'b1;
              state_r      <= LAUNCH;
            end
          end
          LAUNCH: begin
            wait_cnt_r <= '0;
            state_r    <= WAIT;
          end
          WAIT: begin
            wait_cnt_r <= wait_nx_s;
            // A done arriving on the last allowed cycle still counts as a capture
            if (acc_done) begin
              last_digit <= acc_digit;
              if (hit_s) begin
                correct_cnt <= correct_cnt + (IDX_W+1)'(1);
              end
              state_r <= DRAIN;
            end else if (wait_nx_s == WAIT_W'(TIMEOUT)) begin
              err_timeout <= 1'b1;
              batch_done  <= 1'b1;
              state_r     <= REPORT;
            end
          end
          DRAIN: begin
            if (!acc_done) begin
              state_r <= NEXT;
            end
          end
          NEXT: begin
            if (img_sel == IDX_W'(NUM_IMG - 1)) begin
              batch_done <= 1'b1;
              state_r    <= REPORT;
            end else begin
              img_sel   <= img_sel + IDX_W'(1);
              acc_start <= 1'b1;
              state_r   <= LAUNCH;
            end
          end
          REPORT: begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
          default: begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef SCHED_PERF_EN
  logic [15:0] lat_s;

  // Latency of the image being captured, clamped to the 16-bit report range
  always_comb begin
    if (wait_nx_s > WAIT_W'(16'hFFFF)) begin
      lat_s = 16'hFFFF;
    end else begin
      lat_s = wait_nx_s[15:0];
    end
  end

  // Worst-case capture latency of the current batch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_lat <= 16'd0;
    end else if ((state_r == IDLE) && run) begin
      max_lat <= 16'd0;
    end else if ((state_r == WAIT) && !abort && acc_done && (lat_s > max_lat)) begin
      max_lat <= lat_s;
    end else begin
      max_lat <= max_lat;
    end
  end
`else
  assign max_lat = 16'd0;
`endif

endmodule

// File: tb/tb_mnist_batch_sched.sv
// Directed scoreboard bench for mnist_batch_sched with a behavioural accelerator model.
module tb_mnist_batch_sched;
  localparam int NUM_IMG = 3;
  localparam int IDX_W   = 4;
  localparam int TIMEOUT = 150;
  localparam int CYC_W   = 32;

  logic             clk = 1'b0;
  logic             rst_n, run, abort;
  logic [IDX_W-1:0] img_sel;
  logic [3:0]       exp_digit;
  logic             acc_start;
  logic             acc_done = 1'b0;
  logic [3:0]       acc_digit = 4'd0;
  logic             busy, batch_done;
  logic [IDX_W:0]   correct_cnt;
  logic [3:0]       last_digit;
  logic             err_timeout;
  logic [CYC_W-1:0] total_cycles;
  logic [15:0]      max_lat;

  mnist_batch_sched #(.NUM_IMG(NUM_IMG), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT), .CYC_W(CYC_W)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .abort(abort), .img_sel(img_sel),
    .exp_digit(exp_digit), .acc_start(acc_start), .acc_done(acc_done), .acc_digit(acc_digit),
    .busy(busy), .batch_done(batch_done), .correct_cnt(correct_cnt), .last_digit(last_digit),
    .err_timeout(err_timeout), .total_cycles(total_cycles), .max_lat(max_lat)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  logic [3:0] label [0:15];
  logic [3:0] dig   [0:15];
  int         lat   [0:15];
  int         hold;
  bit         never;
  assign exp_digit = label[img_sel];

  // Accelerator model: done rises lat cycles into WAIT and is held for hold cycles
  int m_cnt, m_hold;
  bit m_active;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n || !busy) begin
      acc_done = 1'b0;
      m_active = 1'b0;
    end else if (acc_start) begin
      m_cnt    = lat[img_sel];
      m_active = 1'b1;
      acc_done = 1'b0;
    end else if (m_active) begin
      if (acc_done) begin
        if (m_hold > 1) m_hold--;
        else begin
          acc_done = 1'b0;
          m_active = 1'b0;
        end
      end else begin
        m_cnt--;
        if (m_cnt <= 0) begin
          if (!never) begin
            acc_done  = 1'b1;
            acc_digit = dig[img_sel];
            m_hold    = hold;
          end else m_active = 1'b0;
        end
      end
    end
  end

  // Monitor: start/done pulse counts and shortest done-fall to next start gap
  bit mon_clr;
  int n_start, n_bd, min_gap, mcyc, fall_cyc;
  logic prev_done;
  always @(posedge clk) begin
    if (mon_clr) begin
      n_start = 0; n_bd = 0; min_gap = 1000; fall_cyc = -1; prev_done = 1'b0; mcyc = 0;
    end else begin
      mcyc++;
      if (acc_start) begin
        n_start++;
        if (fall_cyc >= 0 && (mcyc - fall_cyc) < min_gap) min_gap = mcyc - fall_cyc;
      end
      if (batch_done) n_bd++;
      if (prev_done && !acc_done) fall_cyc = mcyc;
      prev_done = acc_done;
    end
  end

  typedef struct {
    logic [4:0]  cnt;
    logic [3:0]  last;
    logic        err;
    logic [3:0]  sel;
    logic [31:0] tot;
    logic [15:0] ml;
  } exp_t;
  exp_t sb[$];

  function automatic logic [15:0] ml(input int v);
`ifdef SCHED_PERF_EN
    return 16'(v);
`else
    return 16'd0;
`endif
  endfunction

  task automatic set_imgs(input int l0, input int l1, input int l2,
                          input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2);
    lat[0] = l0; lat[1] = l1; lat[2] = l2;
    dig[0] = d0; dig[1] = d1; dig[2] = d2;
  endtask

  task automatic clear_mon();
    @(negedge clk); mon_clr = 1'b1;
    @(negedge clk); mon_clr = 1'b0;
  endtask

  task automatic start_batch();
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
  endtask

  task automatic wait_start(input logic [3:0] sel, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (acc_start && img_sel == sel) ok = 1'b1;
    end
  endtask

  task automatic wait_report(input string tag);
    bit   seen;
    exp_t e;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (batch_done) seen = 1'b1;
    end
    check({tag, " batch_done seen"}, seen, 1'b1);
    if (sb.size() > 0) e = sb.pop_front();
    else e = '{cnt: 5'd0, last: 4'd0, err: 1'b0, sel: 4'd0, tot: 32'd0, ml: 16'd0};
    if (seen) begin
      check({tag, " correct_cnt"}, correct_cnt, e.cnt);
      check({tag, " last_digit"}, last_digit, e.last);
      check({tag, " err_timeout"}, err_timeout, e.err);
      check({tag, " img_sel"}, img_sel, e.sel);
      check({tag, " total_cycles"}, total_cycles, e.tot);
      check({tag, " max_lat"}, max_lat, e.ml);
      check({tag, " busy in report"}, busy, 1'b1);
      @(negedge clk);
      check({tag, " batch_done one pulse"}, batch_done, 1'b0);
      check({tag, " idle after report"}, busy, 1'b0);
    end
  endtask

  bit ok;

  initial begin
    for (int i = 0; i < 16; i++) begin
      label[i] = 4'd0; dig[i] = 4'd0; lat[i] = 10;
    end
    label[0] = 4'd6; label[1] = 4'd2; label[2] = 4'd1;
    hold = 1; never = 1'b0;
    rst_n = 1'b0; run = 1'b0; abort = 1'b0; mon_clr = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    mon_clr = 1'b0;
    @(negedge clk);
    check("reset outputs", {img_sel, acc_start, busy, batch_done, correct_cnt, last_digit,
                            err_timeout, total_cycles, max_lat}, 65'd0);

    // All correct at 100 cycles each; a run pulse mid-batch must be ignored
    set_imgs(100, 100, 100, 4'd6, 4'd2, 4'd1);
    sb.push_back('{cnt: 5'd3, last: 4'd1, err: 1'b0, sel: 4'd2, tot: 32'd309, ml: ml(100)});
    clear_mon();
    start_batch();
    repeat (20) @(negedge clk);
    run = 1'b1;
    @(negedge clk); run = 1'b0;
    wait_report("all_ok");
    check("all_ok acc_start pulses", n_start, 3);
    check("all_ok batch_done pulses", n_bd, 1);

    // One misprediction
    set_imgs(100, 100, 100, 4'd6, 4'd7, 4'd1);
    sb.push_back('{cnt: 5'd2, last: 4'd1, err: 1'b0, sel: 4'd2, tot: 32'd309, ml: ml(100)});
    start_batch();
    wait_report("one_wrong");

    // Accelerator never answers: timeout after TIMEOUT wait cycles of image 0
    never = 1'b1;
    sb.push_back('{cnt: 5'd0, last: 4'd1, err: 1'b1, sel: 4'd0, tot: 32'd151, ml: ml(0)});
    clear_mon();
    start_batch();
    wait_report("timeout");
    check("timeout acc_start pulses", n_start, 1);
    check("timeout err sticky", err_timeout, 1'b1);
    never = 1'b0;

    // Done held 20 cycles: single capture, gap of at least 2 cycles before next start
    hold = 20;
    set_imgs(30, 30, 30, 4'd6, 4'd2, 4'd1);
    sb.push_back('{cnt: 5'd3, last: 4'd1, err: 1'b0, sel: 4'd2, tot: 32'd156, ml: ml(30)});
    clear_mon();
    start_batch();
    wait_report("held_done");
    check("held_done acc_start pulses", n_start, 3);
    check("held_done min gap ok", (min_gap >= 2), 1'b1);
    hold = 1;

    // Done exactly at the TIMEOUT cycle wins; one cycle later times out
    set_imgs(150, 151, 10, 4'd6, 4'd2, 4'd1);
    sb.push_back('{cnt: 5'd1, last: 4'd6, err: 1'b1, sel: 4'd1, tot: 32'd304, ml: ml(150)});
    start_batch();
    wait_report("edge_timeout");

    // Latencies 40, 90, 60
    set_imgs(40, 90, 60, 4'd6, 4'd2, 4'd1);
    sb.push_back('{cnt: 5'd3, last: 4'd1, err: 1'b0, sel: 4'd2, tot: 32'd199, ml: ml(90)});
    start_batch();
    wait_report("latency");

    // Abort in WAIT of image 1, then restart from a clean batch
    set_imgs(100, 100, 100, 4'd6, 4'd2, 4'd1);
    clear_mon();
    start_batch();
    wait_start(4'd1, 400, ok);
    check("abort image1 launched", ok, 1'b1);
    repeat (10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort busy", busy, 1'b0);
    check("abort acc_start", acc_start, 1'b0);
    check("abort correct_cnt kept", correct_cnt, 5'd1);
    check("abort img_sel kept", img_sel, 4'd1);
    check("abort total kept", total_cycles, 32'd114);
    repeat (20) @(negedge clk);
    check("abort no batch_done", n_bd, 0);
    check("abort total still kept", total_cycles, 32'd114);
    sb.push_back('{cnt: 5'd3, last: 4'd1, err: 1'b0, sel: 4'd2, tot: 32'd309, ml: ml(100)});
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
    check("restart acc_start", acc_start, 1'b1);
    check("restart img_sel", img_sel, 4'd0);
    check("restart correct_cnt", correct_cnt, 5'd0);
    check("restart total", total_cycles, 32'd0);
    wait_report("restart");

    // Asynchronous reset mid-WAIT, between clock edges
    start_batch();
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async reset outputs", {img_sel, acc_start, busy, batch_done, correct_cnt, last_digit,
                                  err_timeout, total_cycles, max_lat}, 65'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post reset idle", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
